butterfly_pipe: RTL and testbench

BUTTERFLY_PIPE -- requirements
Module: butterfly_pipe

---
 rtl/butterfly_pipe.sv | 155 +++++++++++++++
 tb/tb_butterfly_pipe.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/butterfly_pipe.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : butterfly_pipe
//  Purpose  : Radix-2 complex butterfly, out0 = A + B*W, out1 = A - B*W,
//             3-stage pipeline with valid/ready flow control, optional
//             divide-by-2 output scaling, per-component saturation and a
//             sticky saturation flag.
//  Ports    : clk, rst_n (async, active low)
//             in_valid / in_ready      : input handshake
//             a_in, b_in, w_in         : packed complex {re, im} operands
//             out_valid / out_ready    : output handshake
//             out0, out1               : packed complex {re, im} results
//             sat / sat_clr            : sticky clip flag and its clear
//  Revision : 1.0 - initial release
// ============================================================================
module butterfly_pipe #(
    parameter int WIDTH = 32,
    parameter int FRAC  = WIDTH / 2 - 1,
    parameter int SCALE = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic [WIDTH-1:0] w_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out0,
    output logic [WIDTH-1:0] out1,
    output logic             sat,
    input  logic             sat_clr
);

    localparam int HALF = WIDTH / 2;
    localparam int PW   = 2 * HALF;   // full-precision product
    localparam int TW   = PW + 1;     // sum of two products
    localparam int RW   = HALF + 2;   // rounded twiddle product T
    localparam int SW   = HALF + 3;   // A +/- T
    localparam logic [TW-1:0] RND_T = TW'(1) << (FRAC - 1);

    // Single advance enable for the whole pipe: everything moves or holds.
    logic w_en;
    assign w_en     = !out_valid || out_ready;
    assign in_ready = w_en;

    // ------------------------------------------------------------------
    // Stage 1: four partial products, operands sign-extended to PW bits
    // ------------------------------------------------------------------
    logic signed [PW-1:0] w_br_x, w_bi_x, w_wr_x, w_wi_x;
    assign w_br_x = {{HALF{b_in[WIDTH-1]}}, b_in[WIDTH-1:HALF]};
    assign w_bi_x = {{HALF{b_in[HALF-1]}},  b_in[HALF-1:0]};
    assign w_wr_x = {{HALF{w_in[WIDTH-1]}}, w_in[WIDTH-1:HALF]};
    assign w_wi_x = {{HALF{w_in[HALF-1]}},  w_in[HALF-1:0]};

    logic [PW-1:0]    r_p_rr, r_p_ii, r_p_ri, r_p_ir;
    logic [WIDTH-1:0] r_a1, r_a2;
    logic [RW-1:0]    r_tr, r_ti;
    logic             r_v1, r_v2;

    // ------------------------------------------------------------------
    // Stage 2: T = B*W, rounded half toward +inf and truncated to RW bits.
    // With FRAC <= HALF-1 the RW-bit field above FRAC always lies inside
    // the TW-bit sum, so a plain slice equals the arithmetic shift.
    // ------------------------------------------------------------------
    logic [TW-1:0] w_sr, w_si, w_rr, w_ri;
    assign w_sr = {r_p_rr[PW-1], r_p_rr} - {r_p_ii[PW-1], r_p_ii};
    assign w_si = {r_p_ri[PW-1], r_p_ri} + {r_p_ir[PW-1], r_p_ir};
    assign w_rr = w_sr + RND_T;
    assign w_ri = w_si + RND_T;

    // Fraction bits discarded by the rounding are intentionally dropped.
    logic w_unused;
    assign w_unused = ^{w_rr, w_ri};

    // ------------------------------------------------------------------
    // Stage 3: one output component. Returns {clip, value}.
    // ------------------------------------------------------------------
    function automatic logic [HALF:0] lane(input logic [HALF-1:0] a,
                                           input logic [RW-1:0]   t,
                                           input logic            sub);
        logic signed [SW-1:0] ae, te, s, s1, s2;
        logic                 clip;
        ae = {{3{a[HALF-1]}}, a};
        te = {t[RW-1], t};
        s  = sub ? (ae - te) : (ae + te);
        s1 = s + SW'(1);
        s2 = s1 >>> 1;
        if (SCALE != 0) begin
            s = s2;
        end
        // In range only when all bits from HALF-1 upward agree.
        clip = !((&s[SW-1:HALF-1]) || !(|s[SW-1:HALF-1]));
        if (clip) begin
            lane = {1'b1, s[SW-1], {(HALF-1){~s[SW-1]}}};
        end else begin
            lane = {1'b0, s[HALF-1:0]};
        end
    endfunction

    logic [HALF:0] w_l0r, w_l0i, w_l1r, w_l1i;
    logic          w_clip;
    assign w_l0r  = lane(r_a2[WIDTH-1:HALF], r_tr, 1'b0);
    assign w_l0i  = lane(r_a2[HALF-1:0],     r_ti, 1'b0);
    assign w_l1r  = lane(r_a2[WIDTH-1:HALF], r_tr, 1'b1);
    assign w_l1i  = lane(r_a2[HALF-1:0],     r_ti, 1'b1);
    assign w_clip = w_l0r[HALF] | w_l0i[HALF] | w_l1r[HALF] | w_l1i[HALF];

    // Data path registers: no reset, only meaningful alongside their valid.
    always_ff @(posedge clk) begin
        if (w_en) begin
            r_p_rr <= w_br_x * w_wr_x;
            r_p_ii <= w_bi_x * w_wi_x;
            r_p_ri <= w_br_x * w_wi_x;
            r_p_ir <= w_bi_x * w_wr_x;
            r_a1   <= a_in;
            r_tr   <= w_rr[FRAC+RW-1:FRAC];
            r_ti   <= w_ri[FRAC+RW-1:FRAC];
            r_a2   <= r_a1;
        end
    end

    // Control, outputs and sticky flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v1      <= 1'b0;
            r_v2      <= 1'b0;
            out_valid <= 1'b0;
            out0      <= '0;
            out1      <= '0;
            sat       <= 1'b0;
        end else begin
            if (w_en) begin
                r_v1      <= in_valid;
                r_v2      <= r_v1;
                out_valid <= r_v2;
                // Outputs only load real data, so they stay put across bubbles.
                if (r_v2) begin
                    out0 <= {w_l0r[HALF-1:0], w_l0i[HALF-1:0]};
                    out1 <= {w_l1r[HALF-1:0], w_l1i[HALF-1:0]};
                end
            end
            // A clip landing this cycle beats a simultaneous clear.
            if (w_en && r_v2 && w_clip) begin
                sat <= 1'b1;
            end else if (sat_clr) begin
                sat <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_butterfly_pipe.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_butterfly_pipe
//  Purpose  : Self-checking bench for butterfly_pipe. Two instances share the
//             stimulus (SCALE=0 and SCALE=1); an arithmetic reference model
//             plus a 3-slot occupancy model predict every output.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_butterfly_pipe;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic        sat_clr = 1'b0;
    logic [31:0] a_in = '0, b_in = '0, w_in = '0;
    logic        in_ready0, in_ready1, out_valid0, out_valid1, sat0, sat1;
    logic [31:0] o00, o01, o10, o11;

    always #5 clk = ~clk;

    butterfly_pipe #(.WIDTH(32), .FRAC(15), .SCALE(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
        .a_in(a_in), .b_in(b_in), .w_in(w_in), .out_valid(out_valid0),
        .out_ready(out_ready), .out0(o00), .out1(o01), .sat(sat0),
        .sat_clr(sat_clr));

    butterfly_pipe #(.WIDTH(32), .FRAC(15), .SCALE(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
        .a_in(a_in), .b_in(b_in), .w_in(w_in), .out_valid(out_valid1),
        .out_ready(out_ready), .out0(o10), .out1(o11), .sat(sat1),
        .sat_clr(sat_clr));

    typedef struct {
        logic        v;
        logic [31:0] r00, r01, r10, r11;
        logic        c0, c1;
    } ent_t;

    ent_t pipe [3];
    logic es0, es1;
    logic last_acc;
    int   nvec = 0;
    int   nfail = 0;

    function automatic longint sx16(input logic [15:0] x);
        logic signed [15:0] y;
        y = x;
        return longint'(y);
    endfunction

    // One component: sum/difference, optional halving, clamp. {clip, value}
    function automatic logic [16:0] comp(input longint av, input longint tv,
                                         input logic sub, input int scale);
        longint s;
        s = sub ? (av - tv) : (av + tv);
        if (scale != 0) s = (s + 1) >>> 1;
        if (s > 32767)  return {1'b1, 16'h7FFF};
        if (s < -32768) return {1'b1, 16'h8000};
        return {1'b0, 16'(s)};
    endfunction

    function automatic ent_t empty_ent();
        ent_t e;
        e.v = 1'b0; e.r00 = '0; e.r01 = '0; e.r10 = '0; e.r11 = '0;
        e.c0 = 1'b0; e.c1 = 1'b0;
        return e;
    endfunction

    function automatic ent_t model(input logic [31:0] a, input logic [31:0] b,
                                   input logic [31:0] w);
        ent_t e;
        longint ar, ai, br, bi, wr, wi, tr, ti;
        logic [16:0] p, q, r, s;
        ar = sx16(a[31:16]); ai = sx16(a[15:0]);
        br = sx16(b[31:16]); bi = sx16(b[15:0]);
        wr = sx16(w[31:16]); wi = sx16(w[15:0]);
        tr = (br * wr - bi * wi + 16384) >>> 15;
        ti = (br * wi + bi * wr + 16384) >>> 15;
        e.v = 1'b1;
        p = comp(ar, tr, 1'b0, 0); q = comp(ai, ti, 1'b0, 0);
        r = comp(ar, tr, 1'b1, 0); s = comp(ai, ti, 1'b1, 0);
        e.r00 = {p[15:0], q[15:0]}; e.r01 = {r[15:0], s[15:0]};
        e.c0  = p[16] | q[16] | r[16] | s[16];
        p = comp(ar, tr, 1'b0, 1); q = comp(ai, ti, 1'b0, 1);
        r = comp(ar, tr, 1'b1, 1); s = comp(ai, ti, 1'b1, 1);
        e.r10 = {p[15:0], q[15:0]}; e.r11 = {r[15:0], s[15:0]};
        e.c1  = p[16] | q[16] | r[16] | s[16];
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_out();
        chk("out_valid0", {31'b0, out_valid0}, {31'b0, pipe[2].v});
        chk("out_valid1", {31'b0, out_valid1}, {31'b0, pipe[2].v});
        if (pipe[2].v) begin
            chk("s0_out0", o00, pipe[2].r00);
            chk("s0_out1", o01, pipe[2].r01);
            chk("s1_out0", o10, pipe[2].r10);
            chk("s1_out1", o11, pipe[2].r11);
        end
        chk("sat0", {31'b0, sat0}, {31'b0, es0});
        chk("sat1", {31'b0, sat1}, {31'b0, es1});
    endtask

    // One clock cycle: drive inputs after a falling edge, check at the next.
    task automatic tick(input logic iv, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] w, input logic ordy, input logic clr);
        logic en;
        in_valid = iv; a_in = a; b_in = b; w_in = w;
        out_ready = ordy; sat_clr = clr;
        nvec++;
        #1;
        en = !pipe[2].v || ordy;
        chk("in_ready0", {31'b0, in_ready0}, {31'b0, en});
        chk("in_ready1", {31'b0, in_ready1}, {31'b0, en});
        last_acc = iv && en;
        @(posedge clk);
        if (en && pipe[1].v && pipe[1].c0) es0 = 1'b1; else if (clr) es0 = 1'b0;
        if (en && pipe[1].v && pipe[1].c1) es1 = 1'b1; else if (clr) es1 = 1'b0;
        if (en) begin
            pipe[2] = pipe[1];
            pipe[1] = pipe[0];
            pipe[0] = iv ? model(a, b, w) : empty_ent();
        end
        @(negedge clk);
        check_out();
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) pipe[i] = empty_ent();
        es0 = 1'b0; es1 = 1'b0;
    endtask

    task automatic reset_checks();
        chk("rst_out_valid0", {31'b0, out_valid0}, 32'd0);
        chk("rst_out_valid1", {31'b0, out_valid1}, 32'd0);
        chk("rst_out0", o00, 32'd0);
        chk("rst_out1", o01, 32'd0);
        chk("rst_sat0", {31'b0, sat0}, 32'd0);
        chk("rst_in_ready0", {31'b0, in_ready0}, 32'd1);
    endtask

    task automatic bubbles(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, '0, '0, '0, 1'b1, 1'b0);
    endtask

    logic [31:0] sa [6], sb [6], sw [6];

    initial begin
        // ---------------- power-on reset ----------------
        model_reset();
        #1;
        reset_checks();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("post_rst_in_ready", {31'b0, in_ready0}, 32'd1);

        // ---------------- basic butterfly, latency ----------------
        tick(1'b1, {16'd100, 16'd50}, {16'd200, -16'sd40}, {16'h4000, 16'h0}, 1'b1, 1'b0);
        bubbles(2);
        chk("basic_out0", o00, {16'd200, 16'd30});
        chk("basic_out1", o01, {16'd0, 16'd70});
        chk("basic_sat", {31'b0, sat0}, 32'd0);
        bubbles(1);

        // ---------------- positive clip / scaled ----------------
        tick(1'b1, {16'h7FFF, 16'h0}, {16'h7FFF, 16'h0}, {16'h4000, 16'h0}, 1'b1, 1'b0);
        bubbles(2);
        chk("clip_out0", o00, {16'h7FFF, 16'h0});
        chk("clip_out1", o01, {16'd16383, 16'h0});
        chk("scaled_out0", o10, {16'd24576, 16'h0});
        chk("scaled_out1", o11, {16'd8192, 16'h0});
        chk("clip_sat0", {31'b0, sat0}, 32'd1);
        chk("scaled_sat1", {31'b0, sat1}, 32'd0);
        bubbles(2);
        tick(1'b0, '0, '0, '0, 1'b1, 1'b1);
        chk("sat_cleared", {31'b0, sat0}, 32'd0);

        // ---------------- -1 * -1, clip colliding with clear ----------------
        tick(1'b1, 32'h0, {16'h8000, 16'h0}, {16'h8000, 16'h0}, 1'b1, 1'b0);
        tick(1'b0, '0, '0, '0, 1'b1, 1'b0);
        tick(1'b0, '0, '0, '0, 1'b1, 1'b1);
        chk("neg_out0", o00, {16'h7FFF, 16'h0});
        chk("neg_out1", o01, {16'h8000, 16'h0});
        chk("neg_s_out0", o10, {16'h4000, 16'h0});
        chk("neg_s_out1", o11, {16'hC000, 16'h0});
        chk("sat_wins_clr", {31'b0, sat0}, 32'd1);
        tick(1'b0, '0, '0, '0, 1'b1, 1'b1);

        // ---------------- stream of 6 with a 5-cycle stall ----------------
        for (int i = 0; i < 6; i++) begin
            sa[i] = $urandom; sb[i] = $urandom; sw[i] = $urandom;
        end
        begin
            int k;
            k = 0;
            for (int cyc = 0; cyc < 20; cyc++) begin
                tick(k < 6, (k < 6) ? sa[k] : 32'h0, (k < 6) ? sb[k] : 32'h0,
                     (k < 6) ? sw[k] : 32'h0, !(cyc >= 4 && cyc < 9), 1'b0);
                if (last_acc) k++;
            end
            chk("stream_all_accepted", k, 32'd6);
        end

        // ---------------- reset with items in flight ----------------
        tick(1'b1, $urandom, $urandom, $urandom, 1'b1, 1'b0);
        tick(1'b1, $urandom, $urandom, $urandom, 1'b1, 1'b0);
        tick(1'b1, $urandom, $urandom, $urandom, 1'b1, 1'b0);
        rst_n = 1'b0;
        in_valid = 1'b0;
        #1;
        model_reset();
        reset_checks();
        @(negedge clk);
        rst_n = 1'b1;
        tick(1'b1, {16'd100, 16'd50}, {16'd200, -16'sd40}, {16'h4000, 16'h0}, 1'b1, 1'b0);
        bubbles(3);

        // ---------------- randomized traffic ----------------
        tick(1'b0, '0, '0, '0, 1'b1, 1'b1);
        for (int i = 0; i < 1000; i++) begin
            tick(1'($urandom_range(0, 1)), $urandom, $urandom, $urandom,
                 1'($urandom_range(0, 1)), ($urandom_range(0, 9) == 0));
        end
        bubbles(4);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
`default_nettype wire
